// File: rtl/pio_poll_master_pkg.sv
// Shared SoC definitions for the PIO poll master: FSM state encoding and
// the fixed Avalon-MM register address of the polled PIO.
package pio_poll_master_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2
  } poll_state_e;

  localparam logic [1:0] AVM_ADDR = 2'd0;

endpackage

// File: rtl/poll_divider.sv
// Poll-period divider: counts 0..POLL_DIV-1 while enabled, held at 0 otherwise,
// and flags the last count of each period with tick.
module poll_divider #(
  parameter int unsigned POLL_DIV = 50000,
  localparam int unsigned CW = $clog2(POLL_DIV)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          tick
);

  localparam logic [CW-1:0] LAST = CW'(POLL_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    count_d = '0;
    if (enable) begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end
  end

  // NOTE: reset is asynchronous active-low, so it sits in the sensitivity list
  // and takes priority over the clocked update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tick  = enable && (count_q == LAST);

endmodule

// File: rtl/pio_poll_master.sv
// Periodically reads a PIO over Avalon-MM, tracks the sampled level and
// raises a ready/valid change event, flagging overwritten events as overrun.
module pio_poll_master
  import pio_poll_master_pkg::*;
#(
  parameter int unsigned POLL_DIV = 50000,
  parameter int unsigned W        = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  output logic [1:0]   avm_address,
  output logic         avm_read,
  input  logic [31:0]  avm_readdata,
  output logic [W-1:0] level,
  output logic [W-1:0] evt_data,
  output logic         evt_valid,
  input  logic         evt_ready,
  output logic         overrun,
  input  logic         overrun_clr
);

  poll_state_e  state_q, state_d;
  logic [W-1:0] level_q, level_d;
  logic [W-1:0] evt_data_q, evt_data_d;
  logic         evt_valid_q, evt_valid_d;
  logic         overrun_q, overrun_d;

  logic         tick;
  logic [W-1:0] sample;
  logic         new_evt;
  logic         ovr_set;

  poll_divider #(.POLL_DIV(POLL_DIV)) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .count   (),
    .tick    (tick)
  );

  // Only the low W bits of the PIO register are meaningful.
  if (W < 32) begin : g_hi_bits
    logic unused_hi;
    assign unused_hi = ^avm_readdata[31:W];
  end

  assign sample  = avm_readdata[W-1:0];
  assign new_evt = (state_q == CAPTURE) && (sample != level_q);
  assign ovr_set = new_evt && evt_valid_q && !evt_ready;

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    evt_data_d  = evt_data_q;
    evt_valid_d = evt_valid_q;
    overrun_d   = overrun_q;

    // A started transaction always completes, regardless of enable.
    unique case (state_q)
      IDLE:    if (tick) state_d = READ;
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new event takes precedence over clearing the accepted one.
    if (new_evt) begin
      level_d     = sample;
      evt_data_d  = sample;
      evt_valid_d = 1'b1;
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end

    if (ovr_set) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      level_q     <= '0;
      evt_data_q  <= '0;
      evt_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      evt_data_q  <= evt_data_d;
      evt_valid_q <= evt_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign avm_address = AVM_ADDR;
  assign avm_read    = (state_q == READ);
  assign level       = level_q;
  assign evt_data    = evt_data_q;
  assign evt_valid   = evt_valid_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_pio_poll_master.sv
// Randomized self-checking bench for pio_poll_master against a behavioural
// model built from poll-period arithmetic and event/handshake rules.
module tb_pio_poll_master;

  localparam int unsigned P = 4;
  localparam int unsigned W = 4;

  logic         clk;
  logic         reset_n;
  logic         enable;
  logic [1:0]   avm_address;
  logic         avm_read;
  logic [31:0]  avm_readdata;
  logic [W-1:0] level;
  logic [W-1:0] evt_data;
  logic         evt_valid;
  logic         evt_ready;
  logic         overrun;
  logic         overrun_clr;

  logic [31:0]  slave_val;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc;

  // Reference model state
  int           k;
  bit           m_read, m_cap, m_valid, m_ovr;
  logic [W-1:0] m_resp, m_level, m_evt_data;

  pio_poll_master #(.POLL_DIV(P), .W(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .avm_address  (avm_address),
    .avm_read     (avm_read),
    .avm_readdata (avm_readdata),
    .level        (level),
    .evt_data     (evt_data),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latency-1 slave; returns noise whenever it is not being read.
  always @(posedge clk) avm_readdata <= avm_read ? slave_val : $urandom();

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    k = 0; m_read = 0; m_cap = 0; m_valid = 0; m_ovr = 0;
    m_resp = '0; m_level = '0; m_evt_data = '0;
  endtask

  // One clock edge of the reference behaviour, using the inputs held across it.
  task automatic model_edge();
    bit ev, ovr_set, cap_next;
    ev      = m_cap && (m_resp != m_level);
    ovr_set = ev && m_valid && !evt_ready;
    if (ev) begin
      m_level = m_resp; m_evt_data = m_resp; m_valid = 1;
    end else if (m_valid && evt_ready) begin
      m_valid = 0;
    end
    if (ovr_set) m_ovr = 1;
    else if (overrun_clr) m_ovr = 0;
    cap_next = m_read;
    if (m_read) m_resp = slave_val[W-1:0];
    // Strobes land every P enabled edges counted from enable (re)start.
    k      = enable ? k + 1 : 0;
    m_read = enable && (k % P == 0);
    m_cap  = cap_next;
  endtask

  task automatic compare_all();
    check("avm_read",    avm_read,    m_read);
    check("avm_address", avm_address, 0);
    check("level",       level,       m_level);
    check("evt_valid",   evt_valid,   m_valid);
    check("evt_data",    evt_data,    m_evt_data);
    check("overrun",     overrun,     m_ovr);
  endtask

  // Called at a negedge with inputs already driven; ends at the next negedge.
  task automatic step();
    if (reset_n && evt_valid && evt_ready) n_acc++;
    @(posedge clk);
    if (reset_n) model_edge();
    else model_reset();
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    reset_n = 1'b0; enable = 1'b0; evt_ready = 1'b0; overrun_clr = 1'b0;
    slave_val = '0; n_acc = 0;
    model_reset();
    #1;
    compare_all();
    repeat (2) step();
    reset_n = 1'b1;

    // Constant slave 0x3: periodic strobes, a single event.
    enable = 1'b1; evt_ready = 1'b1; slave_val = 32'h3; n_acc = 0;
    repeat (5 * P) step();
    check("s1_events", n_acc, 1);
    check("s1_level",  level, 4'h3);

    // Overrun on an unaccepted event, then cleared.
    pulse_reset();
    evt_ready = 1'b0; slave_val = 32'h3;
    n = 0;
    while (!m_valid && n < 4 * P) begin step(); n++; end
    check("s2_first_wait", n < 4 * P, 1);
    check("s2_first_data", evt_data, 4'h3);
    slave_val = 32'h5;
    repeat (2 * P) step();
    check("s2_ovr_data", evt_data, 4'h5);
    check("s2_ovr_set",  overrun,  1);
    overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
    check("s2_ovr_clr",  overrun,  0);

    // Accept coinciding with a new event 0x9.
    slave_val = 32'h9;
    n = 0;
    while (!(m_cap && m_resp != m_level) && n < 4 * P) begin step(); n++; end
    check("s3_wait", n < 4 * P, 1);
    evt_ready = 1'b1;
    step();
    check("s3_valid", evt_valid, 1);
    check("s3_data",  evt_data,  4'h9);
    check("s3_ovr",   overrun,   0);

    // Enable dropped during READ: capture completes, polling stops.
    slave_val = 32'hA;
    n = 0;
    while (!m_read && n < 4 * P) begin step(); n++; end
    check("s4_wait", n < 4 * P, 1);
    enable = 1'b0;
    n = 0;
    repeat (3 * P) begin step(); if (avm_read) n++; end
    check("s4_no_strobe", n, 0);
    check("s4_level",     level, 4'hA);
    check("s4_count",     dut.u_div.count_q, 0);
    enable = 1'b1;
    n = 0;
    do begin step(); n++; end while (!avm_read && n < 3 * P);
    check("s4_reenable_lat", n - 1, P - 1);

    // Reset during CAPTURE with slave 0xF discards the sample.
    slave_val = 32'hF;
    n = 0;
    while (!m_cap && n < 4 * P) begin step(); n++; end
    check("s5_wait", n < 4 * P, 1);
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("s5_read_drop", avm_read, 0);
    check("s5_level",     level,    0);
    repeat (3) step();
    reset_n = 1'b1;
    n = 0;
    do begin step(); n++; end while (!avm_read && n < 3 * P);
    check("s5_first_lat", n - 1, P - 1);
    repeat (P) step();
    check("s5_level_f", level, 4'hF);

    // Upper readdata bits are ignored.
    pulse_reset();
    slave_val = 32'hFFFF_FFF0; n_acc = 0;
    repeat (4 * P) step();
    check("s6_level",  level, 0);
    check("s6_events", n_acc, 0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(5) == 0) slave_val = $urandom();
      enable      = ($urandom_range(9) != 0);
      evt_ready   = $urandom_range(1);
      overrun_clr = ($urandom_range(9) == 0);
      if ($urandom_range(299) == 0) pulse_reset();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pio_poll_master.md
PIO_POLL_MASTER -- requirements
Module: pio_poll_master

Interface
REQ-001 SHALL have parameter POLL_DIV, default 50000: poll period in clk cycles; legal range 3..2^20.
REQ-002 SHALL have parameter W, default 4: number of low readdata bits monitored; legal range 1..32.
REQ-003 SHALL have port clk  input  1  system clock, all logic rising-edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  polling enable.
REQ-006 SHALL have port avm_address  output  2  Avalon-MM read address, constant 0.
REQ-007 SHALL have port avm_read  output  1  Avalon-MM read strobe.
REQ-008 SHALL have port avm_readdata  input  32  slave read data, fixed read latency 1, no waitrequest.
REQ-009 SHALL have port level  output  W  last sampled input value.
REQ-010 SHALL have port evt_data  output  W  new value carried by the pending change event.
REQ-011 SHALL have port evt_valid  output  1  change event pending.
REQ-012 SHALL have port evt_ready  input  1  consumer accepts the event.
REQ-013 SHALL have port overrun  output  1  sticky flag: an unaccepted event was overwritten.
REQ-014 SHALL have port overrun_clr  input  1  synchronous clear of overrun.

Function
REQ-015 SHALL count cycles in a divider counter 0..POLL_DIV-1, wrapping to 0; the counter advances only while enable=1 and is held at 0 while enable=0.
REQ-016 SHALL use FSM states IDLE, READ, CAPTURE; IDLE->READ when the counter equals POLL_DIV-1 and enable=1; READ->CAPTURE unconditionally; CAPTURE->IDLE unconditionally.
REQ-017 SHALL assert avm_read for exactly one cycle, in state READ; avm_address SHALL be 0 at all times.
REQ-018 SHALL sample avm_readdata[W-1:0] in state CAPTURE, i.e. one cycle after the strobe; bits 31:W are ignored.
REQ-019 Steady-state read strobes SHALL be spaced exactly POLL_DIV cycles apart while enable stays 1.
REQ-020 Deasserting enable in READ or CAPTURE SHALL NOT abort the transaction; the capture completes and the FSM returns to IDLE.
REQ-021 On capture, if the sample differs from level, level SHALL update to the sample on the next edge and an event SHALL be raised; if equal, no event.
REQ-022 Raising an event SHALL load evt_data with the sample and set evt_valid=1.
REQ-023 Handshake: an event is accepted on a cycle with evt_valid=1 and evt_ready=1; evt_valid SHALL then clear, unless a new event is raised in the same cycle.
REQ-024 Simultaneous accept and new event: the old event is accepted, the new one is loaded, evt_valid stays 1, and overrun is not set.
REQ-025 New event while evt_valid=1 and evt_ready=0: evt_data is overwritten with the newest value and overrun SHALL be set to 1.
REQ-026 overrun SHALL clear on overrun_clr=1; if a set and a clear occur in the same cycle, set wins.
REQ-027 evt_data and evt_valid SHALL remain stable while evt_valid=1 and evt_ready=0, except when overwritten per REQ-025.

Reset
REQ-028 While reset_n=0: FSM=IDLE, counter=0, avm_read=0, level=0, evt_data=0, evt_valid=0, overrun=0.
REQ-029 An assertion of reset_n in READ or CAPTURE SHALL drop avm_read immediately and discard the capture.
REQ-030 After reset release, the first read strobe SHALL occur POLL_DIV-1 cycles after the first enabled edge; a first sample that is nonzero raises an event.

Structure
REQ-031 The FSM state enum and the address constant 0 SHALL live in the shared SoC package.
REQ-032 The divider SHALL be one sub-module, poll_divider (count, wrap, tick output); everything else stays in pio_poll_master.

Verification
REQ-033 POLL_DIV=4, W=4, slave constant 0x3, enable=1, evt_ready=1 -> strobes every 4 cycles; exactly one event with evt_data=0x3; level=0x3.
REQ-034 Slave steps 0x3->0x5, evt_ready=0 -> first event 0x3 pending; next change sets evt_data=0x5 and overrun=1; overrun_clr pulse -> overrun=0.
REQ-035 evt_ready=1 on the same cycle a new event 0x9 is loaded -> evt_valid stays 1, evt_data=0x9, overrun=0.
REQ-036 enable dropped on the READ cycle -> capture still updates level; no further strobes; counter=0; re-enable -> next strobe after POLL_DIV-1 cycles.
REQ-037 reset_n asserted during CAPTURE with slave value 0xF -> all outputs 0, no event; after release, polling restarts per REQ-030.
REQ-038 Slave readdata=0xFFFF_FFF0, W=4 -> level stays 0 and no event is raised.
